// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding for the counter sequencer.
package counter_ctrl_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/counter_ctrl_load_counter.sv
// load_counter: clearable up-counter; clear wins over increment.
module load_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (inc) q <= q + 1'b1;
    end
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause sequencer with prescaler and terminal-count
// compare driving a loadable up-counter; one-shot or periodic operation.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               periodic,
    input  logic [WIDTH-1:0]   term_val,
    input  logic [PRE_W-1:0]   prescale,
    output logic [WIDTH-1:0]   cnt_q,
    output logic               tick,
    output logic               wrap,
    output logic               done,
    output logic               busy,
    output logic [STATE_W-1:0] state_o
);
    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d, pre_q, pre_d;
    logic [WIDTH-1:0]   term_q, term_d;
    logic               per_q, per_d;
    logic               last, clr, inc;

    assign last    = cnt_q == term_q;
    assign tick    = (state_q == S_RUN) && (pre_cnt_q == pre_q) && !pause;
    assign wrap    = tick && last && per_q && !stop;
    assign done    = state_q == S_DONE;
    assign busy    = state_q != S_IDLE;
    assign state_o = state_q;
    assign clr     = (busy && stop) || (state_q == S_LOAD) || wrap;
    assign inc     = tick && !last;

    load_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (inc),
        .q    (cnt_q)
    );

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        term_d    = term_q;
        pre_d     = pre_q;
        per_d     = per_q;
        case (state_q)
            S_IDLE: if (start && !stop) begin
                state_d = S_LOAD;
                term_d  = term_val;
                pre_d   = prescale;
                per_d   = periodic;
            end
            S_LOAD: begin
                state_d   = S_RUN;
                pre_cnt_d = '0;
            end
            S_RUN: begin
                if (pause) state_d = S_PAUSE;
                else if (tick) begin
                    pre_cnt_d = '0;
                    state_d   = (last && !per_q) ? S_DONE : S_RUN;
                end else pre_cnt_d = pre_cnt_q + 1'b1;
            end
            S_PAUSE: state_d = pause ? S_PAUSE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides whatever the state logic decided.
        if (busy && stop) begin
            state_d   = S_IDLE;
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            term_q    <= '0;
            pre_q     <= '0;
            per_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            term_q    <= term_d;
            pre_q     <= pre_d;
            per_q     <= per_d;
        end
    end
endmodule
